multi_trigger_logic: RTL and testbench

Parametrised scope trigger unit and successor to the fixed 5-channel trigger_logic. It combines NUM_CH channel trigger lines and one protocol trigger under per-source enables, in a selectable AND/OR mode. It fires only on a rising edge of the combined condition while armed, then holds `triggered` until the capture engine reports completion. A programmable holdoff follows before the unit re-arms, and a saturating counter tracks the number of trigger events. It sits between the channel comparators/protocol decoders and the capture/RAM controller.

---
 rtl/trig_pkg.sv | 17 +
 rtl/trig_cond.sv | 51 +++++
 rtl/multi_trigger_logic.sv | 138 +++++++++++++
 tb/tb_multi_trigger_logic.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared definitions for the multi-channel scope trigger.
//   trig_state_t : trigger FSM state encoding
//   MODE_AND     : condition = every enabled source high
//   MODE_OR      : condition = any enabled source high
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    HOLDOFF   = 2'd3
  } trig_state_t;

  localparam logic MODE_AND = 1'b0;
  localparam logic MODE_OR  = 1'b1;

endpackage

// File: rtl/trig_cond.sv
// Trigger condition builder: masks the channel and protocol trigger lines
// with their enables, reduces them in AND or OR mode, registers the result
// and reports a rising edge of the combined condition.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ch_trig, ch_en  per-channel trigger level and enable
//   pro_trig, pro_en protocol trigger level and enable
//   mode            MODE_AND / MODE_OR
//   cond_edge       combined condition high now and low last cycle
module trig_cond
  import trig_pkg::*;
#(
  parameter int NUM_CH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              pro_trig,
  input  logic              pro_en,
  input  logic              mode,
  output logic              cond_edge
);

  logic any_en;
  logic and_cond;
  logic or_cond;
  logic cond;
  logic cond_q;

  // A disabled source reads as "satisfied" in AND mode and "absent" in OR
  // mode; with no source enabled at all the condition is forced low.
  always_comb begin
    any_en   = (|ch_en) | pro_en;
    and_cond = any_en & (&(ch_trig | ~ch_en)) & (pro_trig | ~pro_en);
    or_cond  = (|(ch_trig & ch_en)) | (pro_trig & pro_en);
    cond     = (mode == MODE_OR) ? or_cond : and_cond;
  end

  // Previous-cycle condition, used only for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_q <= 1'b0;
    end else begin
      cond_q <= cond;
    end
  end

  assign cond_edge = cond & ~cond_q;

endmodule

// File: rtl/multi_trigger_logic.sv
// Scope trigger unit: fires once per rising edge of the combined trigger
// condition while armed, holds 'triggered' until the capture engine reports
// completion, waits a programmable holdoff, then may re-arm. Keeps a
// saturating count of trigger events.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ch_trig, ch_en     per-channel trigger level and enable
//   pro_trig, pro_en   protocol trigger level and enable
//   mode               0 = AND of enabled sources, 1 = OR
//   armed              capture engine armed (level)
//   set_capture_done   capture finished (pulse)
//   holdoff_cycles     holdoff length after capture done
//   clr_count          synchronous clear of trig_count
//   triggered          trigger latched until capture done
//   trig_pulse         one-cycle strobe when triggered rises
//   trig_count         saturating trigger event count
//   busy               high in TRIGGERED or HOLDOFF
module multi_trigger_logic
  import trig_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              pro_trig,
  input  logic              pro_en,
  input  logic              mode,
  input  logic              armed,
  input  logic              set_capture_done,
  input  logic [HOLD_W-1:0] holdoff_cycles,
  input  logic              clr_count,
  output logic              triggered,
  output logic              trig_pulse,
  output logic [CNT_W-1:0]  trig_count,
  output logic              busy
);

  logic              cond_edge;
  trig_state_t       state_q;
  trig_state_t       state_d;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              fire;
  logic              triggered_q;
  logic              trig_pulse_q;
  logic              busy_q;

  trig_cond #(
    .NUM_CH(NUM_CH)
  ) u_cond (
    .clk      (clk),
    .rst      (rst),
    .ch_trig  (ch_trig),
    .ch_en    (ch_en),
    .pro_trig (pro_trig),
    .pro_en   (pro_en),
    .mode     (mode),
    .cond_edge(cond_edge)
  );

  // Trigger FSM and holdoff counter. Losing 'armed' wins over an edge in
  // the same cycle; a zero holdoff skips HOLDOFF entirely. The counter
  // leaves HOLDOFF when it reads 1, giving exactly holdoff_cycles cycles.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    fire       = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed) state_d = ARMED;
      end
      ARMED: begin
        if (!armed) begin
          state_d = IDLE;
        end else if (cond_edge) begin
          state_d = TRIGGERED;
          fire    = 1'b1;
        end
      end
      TRIGGERED: begin
        if (set_capture_done) begin
          hold_cnt_d = holdoff_cycles;
          state_d    = (holdoff_cycles == '0) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Event counter: clear wins over a plain increment, but a trigger in the
  // clearing cycle still counts as one event.
  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = fire ? CNT_W'(1) : '0;
    end else if (fire && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State and registered outputs, all derived from the next state so the
  // outputs line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      count_q      <= '0;
      triggered_q  <= 1'b0;
      trig_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      count_q      <= count_d;
      triggered_q  <= (state_d == TRIGGERED);
      trig_pulse_q <= fire;
      busy_q       <= (state_d == TRIGGERED) || (state_d == HOLDOFF);
    end
  end

  assign triggered  = triggered_q;
  assign trig_pulse = trig_pulse_q;
  assign trig_count = count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_multi_trigger_logic.sv
// Directed, table-driven bench for multi_trigger_logic (NUM_CH=5, CNT_W=2
// so counter saturation is reachable quickly).
module tb_multi_trigger_logic;

  localparam int NUM_CH = 5;
  localparam int HOLD_W = 16;
  localparam int CNT_W  = 2;
  localparam int NVEC   = 30;

  typedef struct {
    logic [4:0]  ct;
    logic [4:0]  ce;
    logic        pt;
    logic        pe;
    logic        md;
    logic        arm;
    logic        dn;
    logic [15:0] ho;
    logic        clr;
    logic        eTrig;
    logic        ePulse;
    logic [1:0]  eCnt;
    logic        eBusy;
  } vec_t;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] ch_trig;
  logic [NUM_CH-1:0] ch_en;
  logic              pro_trig;
  logic              pro_en;
  logic              mode;
  logic              armed;
  logic              set_capture_done;
  logic [HOLD_W-1:0] holdoff_cycles;
  logic              clr_count;
  logic              triggered;
  logic              trig_pulse;
  logic [CNT_W-1:0]  trig_count;
  logic              busy;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NVEC];

  multi_trigger_logic #(
    .NUM_CH(NUM_CH),
    .HOLD_W(HOLD_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ch_trig         (ch_trig),
    .ch_en           (ch_en),
    .pro_trig        (pro_trig),
    .pro_en          (pro_en),
    .mode            (mode),
    .armed           (armed),
    .set_capture_done(set_capture_done),
    .holdoff_cycles  (holdoff_cycles),
    .clr_count       (clr_count),
    .triggered       (triggered),
    .trig_pulse      (trig_pulse),
    .trig_count      (trig_count),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [4:0] ct, logic [4:0] ce, logic pt, logic pe,
                              logic md, logic arm, logic dn, logic [15:0] ho, logic clr,
                              logic et, logic ep, logic [1:0] ec, logic eb);
    vec_t v;
    v.ct = ct; v.ce = ce; v.pt = pt; v.pe = pe; v.md = md; v.arm = arm;
    v.dn = dn; v.ho = ho; v.clr = clr;
    v.eTrig = et; v.ePulse = ep; v.eCnt = ec; v.eBusy = eb;
    return v;
  endfunction

  // Drive one cycle of inputs, clock it, and leave time to settle.
  task automatic applyStimulus(input vec_t v);
    ch_trig          = v.ct;
    ch_en            = v.ce;
    pro_trig         = v.pt;
    pro_en           = v.pe;
    mode             = v.md;
    armed            = v.arm;
    set_capture_done = v.dn;
    holdoff_cycles   = v.ho;
    clr_count        = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic et, input logic ep,
                          input logic [1:0] ec, input logic eb);
    checkOutput({tag, ".triggered"}, int'(triggered), int'(et));
    checkOutput({tag, ".trig_pulse"}, int'(trig_pulse), int'(ep));
    checkOutput({tag, ".trig_count"}, int'(trig_count), int'(ec));
    checkOutput({tag, ".busy"}, int'(busy), int'(eb));
  endtask

  initial begin
    // AND mode, all channels enabled: basic fire, holdoff of 3 with an
    // ignored edge inside, then re-arm on the 4th cycle after done.
    vecs[0]  = mk(5'b00000, 5'b11111, 0, 0, 0, 1, 0, 16'd3, 0,  0, 0, 2'd0, 0);
    vecs[1]  = mk(5'b11111, 5'b11111, 0, 0, 0, 1, 0, 16'd3, 0,  1, 1, 2'd1, 1);
    vecs[2]  = mk(5'b11111, 5'b11111, 0, 0, 0, 1, 0, 16'd3, 0,  1, 0, 2'd1, 1);
    vecs[3]  = mk(5'b11111, 5'b11111, 0, 0, 0, 1, 1, 16'd3, 0,  0, 0, 2'd1, 1);
    vecs[4]  = mk(5'b00000, 5'b11111, 0, 0, 0, 1, 0, 16'd3, 0,  0, 0, 2'd1, 1);
    vecs[5]  = mk(5'b11111, 5'b11111, 0, 0, 0, 1, 0, 16'd3, 0,  0, 0, 2'd1, 1);
    vecs[6]  = mk(5'b00000, 5'b11111, 0, 0, 0, 1, 0, 16'd3, 0,  0, 0, 2'd1, 0);
    vecs[7]  = mk(5'b00000, 5'b11111, 0, 0, 0, 1, 0, 16'd3, 0,  0, 0, 2'd1, 0);
    // Channel 2 disabled and low still fires; zero holdoff goes to IDLE.
    vecs[8]  = mk(5'b11011, 5'b11011, 0, 0, 0, 1, 0, 16'd3, 0,  1, 1, 2'd2, 1);
    vecs[9]  = mk(5'b11011, 5'b11011, 0, 0, 0, 1, 1, 16'd0, 0,  0, 0, 2'd2, 0);
    vecs[10] = mk(5'b00000, 5'b11111, 0, 0, 0, 1, 0, 16'd0, 0,  0, 0, 2'd2, 0);
    // Same pattern with channel 2 enabled: no trigger.
    vecs[11] = mk(5'b11011, 5'b11111, 0, 0, 0, 1, 0, 16'd0, 0,  0, 0, 2'd2, 0);
    vecs[12] = mk(5'b11011, 5'b11111, 0, 0, 0, 1, 0, 16'd0, 0,  0, 0, 2'd2, 0);
    // OR mode: edge coinciding with armed falling -> IDLE, no trigger.
    vecs[13] = mk(5'b10000, 5'b11111, 0, 0, 1, 0, 0, 16'd0, 0,  0, 0, 2'd2, 0);
    // Condition already high when armed rises: no fire until it re-rises.
    vecs[14] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 0, 16'd0, 0,  0, 0, 2'd2, 0);
    vecs[15] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 0, 16'd0, 0,  0, 0, 2'd2, 0);
    vecs[16] = mk(5'b00000, 5'b11111, 0, 0, 1, 1, 0, 16'd0, 0,  0, 0, 2'd2, 0);
    vecs[17] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 0, 16'd0, 0,  1, 1, 2'd3, 1);
    // Holdoff of one cycle, then a fourth trigger that saturates at 3.
    vecs[18] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 1, 16'd1, 0,  0, 0, 2'd3, 1);
    vecs[19] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 0, 16'd1, 0,  0, 0, 2'd3, 0);
    vecs[20] = mk(5'b00000, 5'b11111, 0, 0, 1, 1, 0, 16'd1, 0,  0, 0, 2'd3, 0);
    vecs[21] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 0, 16'd1, 0,  1, 1, 2'd3, 1);
    vecs[22] = mk(5'b00000, 5'b11111, 0, 0, 1, 1, 1, 16'd0, 0,  0, 0, 2'd3, 0);
    vecs[23] = mk(5'b00000, 5'b11111, 0, 0, 1, 1, 0, 16'd0, 0,  0, 0, 2'd3, 0);
    // clr_count with a trigger gives 1, plain clr gives 0.
    vecs[24] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 0, 16'd0, 1,  1, 1, 2'd1, 1);
    vecs[25] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 0, 16'd0, 1,  1, 0, 2'd0, 1);
    vecs[26] = mk(5'b10000, 5'b11111, 0, 0, 1, 1, 1, 16'd0, 0,  0, 0, 2'd0, 0);
    // Protocol trigger alone in AND mode; done outside TRIGGERED ignored.
    vecs[27] = mk(5'b00000, 5'b00000, 0, 1, 0, 1, 0, 16'd0, 0,  0, 0, 2'd0, 0);
    vecs[28] = mk(5'b00000, 5'b00000, 1, 1, 0, 1, 1, 16'd0, 0,  1, 1, 2'd1, 1);
    vecs[29] = mk(5'b11111, 5'b00000, 1, 1, 0, 1, 0, 16'd0, 0,  1, 0, 2'd1, 1);

    rst = 1'b1;
    ch_trig = '0; ch_en = '0; pro_trig = 0; pro_en = 0; mode = 0;
    armed = 0; set_capture_done = 0; holdoff_cycles = '0; clr_count = 0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 0, 0, 2'd0, 0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].eTrig, vecs[i].ePulse,
               vecs[i].eCnt, vecs[i].eBusy);
    end

    // Asynchronous reset while TRIGGERED, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    checkAll("async_rst", 0, 0, 2'd0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // No source enabled: condition stays low in OR mode however inputs toggle.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mk((i % 2 == 0) ? 5'b11111 : 5'b00000, 5'b00000, i[0], 0, 1, 1, 0,
                       16'd0, 0, 0, 0, 2'd0, 0));
      checkOutput($sformatf("noen%0d.triggered", i), int'(triggered), 0);
      checkOutput($sformatf("noen%0d.busy", i), int'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
